// File: rtl/iis_pkg.sv
// Shared IIS definitions: sample width, slot FSM encoding and scheduling limits
// used by both the sender and the receiver.
package iis_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned MIN_PERIOD = 4;
    localparam int unsigned UNDERRUN_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLOT_L = 2'd1,
        ST_SLOT_R = 2'd2
    } iis_state_e;

endpackage

// File: rtl/iis_tx_sched_if.sv
// Producer-side handshakes for the left/right channels plus the word/strobe
// pair that feeds the IIS sender.
interface iis_tx_sched_if;
    import iis_pkg::*;

    logic    l_valid;
    logic    l_ready;
    sample_t l_data;
    logic    r_valid;
    logic    r_ready;
    sample_t r_data;
    sample_t tx_data;
    logic    tx_wrreq;

    modport master (
        output l_valid, l_data, r_valid, r_data,
        input  l_ready, r_ready, tx_data, tx_wrreq
    );

    modport slave (
        input  l_valid, l_data, r_valid, r_data,
        output l_ready, r_ready, tx_data, tx_wrreq
    );

endinterface

// File: rtl/iis_chan_hold.sv
// One-entry holding register for a single channel, with its full flag,
// ready handshake and saturating count of slots that found it empty.
module iis_chan_hold
    import iis_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  sample_t               data,
    input  logic                  issue,
    input  logic                  clr,
    output logic                  ready_c,
    output sample_t               word_c,
    output logic [UNDERRUN_W-1:0] underrun
);

    localparam logic [UNDERRUN_W-1:0] UR_MAX = '1;

    logic                  full_q, full_d;
    sample_t               hold_q, hold_d;
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
    logic                  load_c;

    // Accepting on the issue edge lets a back-to-back producer never stall.
    assign ready_c  = !full_q || issue;
    assign load_c   = valid && ready_c;
    assign word_c   = full_q ? hold_q : '0;
    assign underrun = underrun_q;

    always_comb begin
        full_d     = full_q;
        hold_d     = hold_q;
        underrun_d = underrun_q;
        if (issue) begin
            full_d = 1'b0;
        end
        if (load_c) begin
            full_d = 1'b1;
            hold_d = data;
        end
        if (clr) begin
            underrun_d = '0;
        end else if (issue && !full_q && (underrun_q != UR_MAX)) begin
            underrun_d = underrun_q + UNDERRUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 1'b0;
            hold_q     <= '0;
            underrun_q <= '0;
        end else begin
            full_q     <= full_d;
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: rtl/iis_tx_sched.sv
// Alternating left/right slot scheduler: every slot period it hands the current
// channel's held sample (or silence) to the IIS sender with a one-cycle strobe.
module iis_tx_sched #(
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned MIN_PERIOD = iis_pkg::MIN_PERIOD
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           enable,
    input  logic [PERIOD_W-1:0]            period,
    input  logic                           clr_underrun,
    output logic [iis_pkg::UNDERRUN_W-1:0] underrun_l,
    output logic [iis_pkg::UNDERRUN_W-1:0] underrun_r,
    iis_tx_sched_if.slave                  bus
);
    import iis_pkg::sample_t;
    import iis_pkg::iis_state_e;
    import iis_pkg::ST_IDLE;
    import iis_pkg::ST_SLOT_L;
    import iis_pkg::ST_SLOT_R;

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    iis_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    sample_t             tx_data_q, tx_data_d;
    logic                tx_wrreq_q, tx_wrreq_d;

    logic [PERIOD_W-1:0] reload_c;
    logic                tick_c;
    logic                issue_l_c, issue_r_c;
    sample_t             l_word_c, r_word_c;

    assign reload_c  = ((period < MIN_P) ? MIN_P : period) - PERIOD_W'(1);
    assign tick_c    = (state_q != ST_IDLE) && (cnt_q == '0);
    assign issue_l_c = tick_c && (state_q == ST_SLOT_L);
    assign issue_r_c = tick_c && (state_q == ST_SLOT_R);

    iis_chan_hold u_hold_l (
        .clk      (pclk),
        .rst_n    (presetn),
        .valid    (bus.l_valid),
        .data     (bus.l_data),
        .issue    (issue_l_c),
        .clr      (clr_underrun),
        .ready_c  (bus.l_ready),
        .word_c   (l_word_c),
        .underrun (underrun_l)
    );

    iis_chan_hold u_hold_r (
        .clk      (pclk),
        .rst_n    (presetn),
        .valid    (bus.r_valid),
        .data     (bus.r_data),
        .issue    (issue_r_c),
        .clr      (clr_underrun),
        .ready_c  (bus.r_ready),
        .word_c   (r_word_c),
        .underrun (underrun_r)
    );

    // Slot sequencing; a tick still issues even if enable drops on that cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_wrreq_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_SLOT_L;
                    cnt_d   = reload_c;
                end
            end
            ST_SLOT_L: begin
                cnt_d = tick_c ? reload_c : (cnt_q - PERIOD_W'(1));
                if (tick_c) state_d = ST_SLOT_R;
            end
            ST_SLOT_R: begin
                cnt_d = tick_c ? reload_c : (cnt_q - PERIOD_W'(1));
                if (tick_c) state_d = ST_SLOT_L;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (tick_c) begin
            tx_wrreq_d = 1'b1;
            tx_data_d  = issue_l_c ? l_word_c : r_word_c;
        end
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_wrreq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_wrreq_q <= tx_wrreq_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wrreq = tx_wrreq_q;

endmodule

// File: tb/tb_iis_tx_sched.sv
// Self-checking bench for iis_tx_sched: directed scenarios plus randomized
// traffic, all checked against a slot-timing/holding-slot reference model.
module tb_iis_tx_sched;

    localparam int MIN_P = 4;

    logic        pclk;
    logic        presetn;
    logic        enable;
    logic [15:0] period;
    logic        clr_underrun;
    logic [7:0]  underrun_l;
    logic [7:0]  underrun_r;

    iis_tx_sched_if bus ();

    iis_tx_sched #(.PERIOD_W(16), .MIN_PERIOD(4)) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .enable       (enable),
        .period       (period),
        .clr_underrun (clr_underrun),
        .underrun_l   (underrun_l),
        .underrun_r   (underrun_r),
        .bus          (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } strobe_t;
    strobe_t     slog[$];
    logic [15:0] drv_l[int];

    // Reference model: strobe k lands k slot-lengths after the start edge,
    // channels alternate starting with left, each channel holds at most one word.
    bit          m_run;
    int          m_t;
    int          m_next;
    bit          m_chan_l;
    bit          m_full[2];
    logic [15:0] m_hold[2];
    logic [15:0] m_data;
    bit          m_wr;
    int          m_ur[2];

    function automatic int peff(input logic [15:0] p);
        return (int'(p) < MIN_P) ? MIN_P : int'(p);
    endfunction

    task automatic model_clear();
        m_run = 0; m_t = 0; m_next = 0; m_chan_l = 1; m_data = '0; m_wr = 0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_hold[i] = '0; m_ur[i] = 0;
        end
    endtask

    task automatic step();
        bit   strobe_nxt;
        int   ch;
        logic exp_rl, exp_rr;
        strobe_nxt = m_run && (m_t + 1 == m_next);
        ch         = m_chan_l ? 0 : 1;
        exp_rl     = !m_full[0] || (strobe_nxt && ch == 0);
        exp_rr     = !m_full[1] || (strobe_nxt && ch == 1);
        checks++;
        if (bus.l_ready !== exp_rl) begin
            failures++;
            $display("FAIL l_ready cyc=%0d: got %b want %b", cyc, bus.l_ready, exp_rl);
        end
        checks++;
        if (bus.r_ready !== exp_rr) begin
            failures++;
            $display("FAIL r_ready cyc=%0d: got %b want %b", cyc, bus.r_ready, exp_rr);
        end
        drv_l[cyc] = bus.l_data;
        @(posedge pclk);
        m_wr = 0;
        if (m_run) begin
            m_t++;
            if (strobe_nxt) begin
                m_wr   = 1;
                m_data = m_full[ch] ? m_hold[ch] : 16'h0000;
                if (!m_full[ch] && m_ur[ch] < 255) m_ur[ch]++;
                m_full[ch] = 0;
                m_next     = m_next + peff(period);
                m_chan_l   = !m_chan_l;
            end
            if (!enable) m_run = 0;
        end else if (enable) begin
            m_run = 1; m_t = 0; m_next = peff(period); m_chan_l = 1;
        end
        if (bus.l_valid && exp_rl) begin m_hold[0] = bus.l_data; m_full[0] = 1; end
        if (bus.r_valid && exp_rr) begin m_hold[1] = bus.r_data; m_full[1] = 1; end
        if (clr_underrun) begin m_ur[0] = 0; m_ur[1] = 0; end
        #1;
        checks++;
        if (bus.tx_wrreq !== m_wr) begin
            failures++;
            $display("FAIL tx_wrreq cyc=%0d: got %b want %b", cyc, bus.tx_wrreq, m_wr);
        end
        checks++;
        if (bus.tx_data !== m_data) begin
            failures++;
            $display("FAIL tx_data cyc=%0d: got %h want %h", cyc, bus.tx_data, m_data);
        end
        checks++;
        if (underrun_l !== 8'(m_ur[0])) begin
            failures++;
            $display("FAIL underrun_l cyc=%0d: got %0d want %0d", cyc, underrun_l, m_ur[0]);
        end
        checks++;
        if (underrun_r !== 8'(m_ur[1])) begin
            failures++;
            $display("FAIL underrun_r cyc=%0d: got %0d want %0d", cyc, underrun_r, m_ur[1]);
        end
        if (bus.tx_wrreq === 1'b1) slog.push_back('{cyc, bus.tx_data});
        cyc++;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        enable = 0; clr_underrun = 0;
        bus.l_valid = 0; bus.r_valid = 0;
        presetn = 0;
        #2;
        checks++;
        if (bus.tx_wrreq !== 1'b0 || bus.tx_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_tx: got wrreq=%b data=%h want 0/0000", bus.tx_wrreq, bus.tx_data);
        end
        checks++;
        if (underrun_l !== 8'd0 || underrun_r !== 8'd0) begin
            failures++;
            $display("FAIL reset_underrun: got %0d/%0d want 0/0", underrun_l, underrun_r);
        end
        checks++;
        if (bus.l_ready !== 1'b1 || bus.r_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b want 1/1", bus.l_ready, bus.r_ready);
        end
        model_clear();
        slog.delete();
        @(posedge pclk);
        #1;
        presetn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        period = 16'd8;
        repeat (3) step();
    endtask

    task automatic test_basic();
        int s;
        do_reset();
        period = 16'd8;
        bus.l_valid = 1; bus.l_data = 16'h1234;
        bus.r_valid = 1; bus.r_data = 16'hABCD;
        step();
        bus.l_valid = 0; bus.r_valid = 0;
        enable = 1; s = cyc;
        repeat (20) step();
        checks++;
        if (slog.size() != 2) begin
            failures++;
            $display("FAIL basic_count: got %0d strobes want 2", slog.size());
        end else begin
            checks++;
            if (slog[0].cyc != s + 8 || slog[0].data !== 16'h1234) begin
                failures++;
                $display("FAIL basic_first: got edge %0d data %h want edge %0d data 1234",
                         slog[0].cyc, slog[0].data, s + 8);
            end
            checks++;
            if (slog[1].cyc != s + 16 || slog[1].data !== 16'hABCD) begin
                failures++;
                $display("FAIL basic_second: got edge %0d data %h want edge %0d data abcd",
                         slog[1].cyc, slog[1].data, s + 16);
            end
        end
        checks++;
        if (underrun_l !== 8'd0 || underrun_r !== 8'd0) begin
            failures++;
            $display("FAIL basic_underrun: got %0d/%0d want 0/0", underrun_l, underrun_r);
        end
    endtask

    task automatic test_clamp();
        int s;
        logic [15:0] a, b;
        do_reset();
        a = 16'($urandom) | 16'h0001;
        b = 16'($urandom) | 16'h0002;
        period = 16'd2;
        bus.l_valid = 1; bus.l_data = a;
        bus.r_valid = 1; bus.r_data = b;
        step();
        bus.l_valid = 0; bus.r_valid = 0;
        enable = 1; s = cyc;
        repeat (14) step();
        checks++;
        if (slog.size() != 3) begin
            failures++;
            $display("FAIL clamp_count: got %0d strobes want 3", slog.size());
        end else begin
            checks++;
            if (slog[0].cyc != s + 4 || slog[1].cyc - slog[0].cyc != 4 || slog[2].cyc - slog[1].cyc != 4) begin
                failures++;
                $display("FAIL clamp_spacing: got edges %0d,%0d,%0d want %0d,%0d,%0d",
                         slog[0].cyc, slog[1].cyc, slog[2].cyc, s + 4, s + 8, s + 12);
            end
            checks++;
            if (slog[0].data !== a || slog[1].data !== b || slog[2].data !== 16'h0000) begin
                failures++;
                $display("FAIL clamp_data: got %h,%h,%h want %h,%h,0000",
                         slog[0].data, slog[1].data, slog[2].data, a, b);
            end
        end
    endtask

    task automatic test_underrun();
        bit found;
        bit zeros;
        do_reset();
        period = 16'd4;
        bus.r_valid = 1;
        enable = 1;
        repeat (41) begin
            bus.r_data = 16'($urandom);
            step();
        end
        checks++;
        if (underrun_l !== 8'd5 || underrun_r !== 8'd0) begin
            failures++;
            $display("FAIL underrun_10slots: got %0d/%0d want 5/0", underrun_l, underrun_r);
        end
        zeros = (slog.size() == 10);
        for (int k = 0; k < slog.size(); k += 2) if (slog[k].data !== 16'h0000) zeros = 0;
        checks++;
        if (!zeros) begin
            failures++;
            $display("FAIL underrun_left_zero: got %0d strobes or nonzero left word, want 10 with left 0000",
                     slog.size());
        end
        repeat (2400) begin
            bus.r_data = 16'($urandom);
            step();
        end
        checks++;
        if (underrun_l !== 8'd255 || underrun_r !== 8'd0) begin
            failures++;
            $display("FAIL underrun_saturate: got %0d/%0d want 255/0", underrun_l, underrun_r);
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_run && (m_t + 1 == m_next) && m_chan_l) found = 1;
            else step();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL underrun_wait_left_tick: got timeout want left tick within 20 cycles");
        end
        clr_underrun = 1;
        step();
        clr_underrun = 0;
        checks++;
        if (underrun_l !== 8'd0 || underrun_r !== 8'd0) begin
            failures++;
            $display("FAIL underrun_clear: got %0d/%0d want 0/0", underrun_l, underrun_r);
        end
        bus.r_valid = 0;
    endtask

    task automatic test_back_to_back();
        int          s;
        logic [15:0] exp_w;
        do_reset();
        period = 16'd5;
        bus.l_valid = 1;
        enable = 1; s = cyc;
        repeat (60) begin
            bus.l_data  = 16'($urandom);
            bus.r_valid = 1'($urandom);
            bus.r_data  = 16'($urandom);
            step();
        end
        bus.l_valid = 0; bus.r_valid = 0;
        checks++;
        if (slog.size() != 11) begin
            failures++;
            $display("FAIL b2b_count: got %0d strobes want 11", slog.size());
        end else begin
            for (int k = 0; k < 11; k += 2) begin
                exp_w = (k == 0) ? drv_l[s] : drv_l[slog[k-2].cyc];
                checks++;
                if (slog[k].data !== exp_w) begin
                    failures++;
                    $display("FAIL b2b_left_word%0d: got %h want %h", k / 2, slog[k].data, exp_w);
                end
            end
        end
        checks++;
        if (underrun_l !== 8'd0) begin
            failures++;
            $display("FAIL b2b_underrun_l: got %0d want 0", underrun_l);
        end
    endtask

    task automatic test_enable_drop();
        int          s, n0;
        bit          found;
        logic [15:0] exp_l;
        do_reset();
        period = 16'd6;
        bus.l_valid = 1; bus.r_valid = 1;
        enable = 1;
        repeat (20) begin
            bus.l_data = 16'($urandom); bus.r_data = 16'($urandom);
            step();
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_run && !m_chan_l && (m_next - m_t) >= 3) found = 1;
            else begin
                bus.l_data = 16'($urandom); bus.r_data = 16'($urandom);
                step();
            end
        end
        checks++;
        if (!found || slog.size() == 0) begin
            failures++;
            $display("FAIL drop_wait_slot_r: got timeout want mid right slot within 20 cycles");
        end else begin
            exp_l = drv_l[slog[$].cyc];
            bus.l_valid = 0; bus.r_valid = 0;
            enable = 0;
            repeat (4) step();
            n0 = slog.size();
            enable = 1; s = cyc;
            repeat (7) step();
            checks++;
            if (slog.size() != n0 + 1 || slog[$].cyc != s + 6 || slog[$].data !== exp_l) begin
                failures++;
                $display("FAIL drop_resume: got %0d new strobes last edge %0d data %h want 1 at edge %0d data %h",
                         slog.size() - n0, slog[$].cyc, slog[$].data, s + 6, exp_l);
            end
        end
    endtask

    task automatic test_period_change();
        int s;
        do_reset();
        period = 16'd8;
        enable = 1; s = cyc;
        repeat (3) step();
        period = 16'd5;
        repeat (12) step();
        checks++;
        if (slog.size() != 2 || slog[0].cyc != s + 8 || slog[1].cyc != s + 13) begin
            failures++;
            $display("FAIL period_change: got %0d strobes want edges %0d,%0d", slog.size(), s + 8, s + 13);
        end
    endtask

    task automatic test_reset_mid();
        int          s;
        logic [15:0] a, b, c, d;
        do_reset();
        a = 16'($urandom) | 16'h0001; b = 16'($urandom); c = 16'($urandom); d = 16'($urandom) | 16'h0100;
        period = 16'd8;
        bus.l_valid = 1; bus.l_data = a;
        bus.r_valid = 1; bus.r_data = b;
        step();
        bus.l_valid = 0; bus.r_valid = 0;
        enable = 1;
        repeat (9) step();
        bus.l_valid = 1; bus.l_data = c;
        step();
        bus.l_valid = 0;
        step();
        do_reset();
        period = 16'd8;
        bus.l_valid = 1; bus.l_data = d;
        step();
        bus.l_valid = 0;
        enable = 1; s = cyc;
        repeat (17) step();
        checks++;
        if (slog.size() != 2) begin
            failures++;
            $display("FAIL rstmid_count: got %0d strobes want 2", slog.size());
        end else begin
            checks++;
            if (slog[0].cyc != s + 8 || slog[0].data !== d) begin
                failures++;
                $display("FAIL rstmid_first_left: got edge %0d data %h want edge %0d data %h",
                         slog[0].cyc, slog[0].data, s + 8, d);
            end
            checks++;
            if (slog[1].data !== 16'h0000 || underrun_r !== 8'd1) begin
                failures++;
                $display("FAIL rstmid_right_discarded: got data %h underrun_r %0d want 0000 and 1",
                         slog[1].data, underrun_r);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        period = 16'($urandom_range(1, 10));
        enable = 1;
        repeat (800) begin
            if ($urandom_range(0, 49) == 0) period = 16'($urandom_range(1, 10));
            if ($urandom_range(0, 59) == 0) enable = !enable;
            clr_underrun = ($urandom_range(0, 99) == 0);
            bus.l_valid  = 1'($urandom);
            bus.r_valid  = 1'($urandom_range(0, 3) == 0);
            bus.l_data   = 16'($urandom);
            bus.r_data   = 16'($urandom);
            step();
        end
        clr_underrun = 0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        presetn = 0; enable = 0; period = 16'd8; clr_underrun = 0;
        bus.l_valid = 0; bus.l_data = '0; bus.r_valid = 0; bus.r_data = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_underrun();
        test_back_to_back();
        test_enable_drop();
        test_period_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iis_tx_sched.md
IIS_TX_SCHED -- requirements
Module: iis_tx_sched

Interface
REQ-001 Parameter PERIOD_W, default 16, width of the slot-period register and counter.
REQ-002 Parameter MIN_PERIOD, default 4, smallest honoured slot period in pclk cycles.
REQ-003 pclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 presetn  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  run/stop for slot scheduling.
REQ-006 period  input  PERIOD_W  pclk cycles per channel slot; sampled at each counter reload.
REQ-007 l_valid, l_ready  input/output  1 each  left producer valid/ready handshake.
REQ-008 l_data  input  16  left sample.
REQ-009 r_valid, r_ready  input/output  1 each  right producer valid/ready handshake.
REQ-010 r_data  input  16  right sample.
REQ-011 tx_data  output  16  sample word to the IIS sender datain.
REQ-012 tx_wrreq  output  1  one-cycle write strobe to the IIS sender wrreq.
REQ-013 clr_underrun  input  1  synchronous clear of both underrun counters.
REQ-014 underrun_l, underrun_r  output  8 each  saturating count of empty slots per channel.

Function
REQ-015 A transfer on a channel SHALL occur on a pclk edge where valid and ready are both high; data is captured into that channel's one-entry holding register and the full flag is set.
REQ-016 ready SHALL be high when the holding register is empty, or when the register is being issued on the same edge (simultaneous issue and load keeps full set with the new word).
REQ-017 FSM states SHALL be IDLE, SLOT_L, SLOT_R; IDLE->SLOT_L when enable=1; SLOT_L->SLOT_R and SLOT_R->SLOT_L on each slot tick; any state->IDLE on the edge after enable=0.
REQ-018 The slot counter SHALL load max(period, MIN_PERIOD)-1 on IDLE->SLOT_L and on each tick, and decrement by 1 per cycle otherwise in SLOT_L/SLOT_R.
REQ-019 A slot tick SHALL be the cycle in SLOT_L/SLOT_R with counter = 0.
REQ-020 On the edge ending a tick cycle, tx_wrreq SHALL be registered high for exactly one cycle and tx_data SHALL be registered with the current channel's holding word (L in SLOT_L, R in SLOT_R), clearing that full flag.
REQ-021 If the current channel's holding register is empty at the tick, tx_data SHALL be 0x0000, tx_wrreq SHALL still pulse, and that channel's underrun counter SHALL increment, saturating at 255.
REQ-022 clr_underrun SHALL zero both counters and take priority over a same-cycle increment.
REQ-023 tx_data SHALL hold its last value between strobes; tx_wrreq SHALL be 0 except on issue cycles.
REQ-024 First issued word after every IDLE->SLOT_L SHALL be a left sample, so L/R order is never swapped.
REQ-025 Dropping enable SHALL retain holding registers and full flags; ready remains per REQ-016 in IDLE.
REQ-026 A period change mid-slot SHALL take effect only at the next reload.

Reset
REQ-027 presetn=0 SHALL immediately force: state IDLE, counter 0, full flags 0, tx_data 0x0000, tx_wrreq 0, underrun_l/r 0; l_ready/r_ready then read 1.
REQ-028 Reset mid-slot SHALL discard held samples without issuing them; after release the first issue is left.

Structure
REQ-029 FSM state encoding, MIN_PERIOD and the 16-bit sample width SHALL live in a shared iis_pkg package used by sender and receiver.
REQ-030 One sub-module, iis_chan_hold (holding register, full flag, ready, saturating underrun counter), SHALL be instantiated twice, for L and R.

Verification
REQ-031 period=8, enable=1, L=0x1234 and R=0xABCD preloaded -> tx_wrreq pulses 8 cycles apart, tx_data 0x1234 then 0xABCD, underrun counts 0.
REQ-032 period=2 -> strobes spaced 4 cycles (MIN_PERIOD clamp).
REQ-033 Left never valid, right fed continuously, 10 slots -> left slots carry 0x0000, underrun_l=5, underrun_r=0; 300 such left slots -> underrun_l=255; clr_underrun -> 0.
REQ-034 l_valid held high with new word each cycle at the left tick -> l_ready high that cycle, old word issued, new word held, no loss or duplication.
REQ-035 enable dropped during SLOT_R then re-raised -> next strobe is left after a full period; held samples unchanged.
REQ-036 presetn pulsed low mid-slot with both channels full -> outputs at reset values asynchronously, first post-reset strobe carries new left data.
